// File: rtl/dram_sched_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dram_sched_if : requester handshakes and DRAM pins of the scheduler     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface dram_sched_if;
  logic        CpuReq;
  logic        CpuWE;
  logic [1:0]  CpuBE;
  logic [20:0] CpuA;      // word address A[21:1]
  logic        CpuAck;
  logic        DmaReq;
  logic [20:0] DmaA;
  logic        DmaAck;
  logic        RefReq;
  logic        RefUrgent;
  logic        RefAck;
  logic [11:0] RA;
  logic        nRAS;
  logic        nCAS;
  logic        nRAMUWE;
  logic        nRAMLWE;
  logic        nOE;
  logic        Busy;

  modport master (
    output CpuReq, CpuWE, CpuBE, CpuA, DmaReq, DmaA, RefReq, RefUrgent,
    input  CpuAck, DmaAck, RefAck, RA, nRAS, nCAS, nRAMUWE, nRAMLWE, nOE, Busy
  );

  modport slave (
    input  CpuReq, CpuWE, CpuBE, CpuA, DmaReq, DmaA, RefReq, RefUrgent,
    output CpuAck, DmaAck, RefAck, RA, nRAS, nCAS, nRAMUWE, nRAMLWE, nOE, Busy
  );
endinterface
`default_nettype wire

// File: rtl/dram_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dram_sched : CPU / DMA / refresh arbiter and fixed-timing DRAM sequencer |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module dram_sched #(
  parameter int TRCD     = 1,
  parameter int TCAS     = 2,
  parameter int TRP      = 2,
  parameter int TRAS_REF = 3
) (
  input  wire logic   CLK_FSB,
  input  wire logic   RES,
  dram_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW   = 3'd1,
    COL   = 3'd2,
    REF_C = 3'd3,
    REF_R = 3'd4,
    PRE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [20:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic        dma_q, dma_d;
  logic        last_dma_q, last_dma_d;
  logic        cpu_served_q, cpu_served_d;
  logic        dma_served_q, dma_served_d;
  logic [11:0] ra_q, ra_d;
  logic        nras_q, nras_d;
  logic        ncas_q, ncas_d;
  logic        nuwe_q, nuwe_d;
  logic        nlwe_q, nlwe_d;
  logic        noe_q, noe_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic        ref_ack_q, ref_ack_d;
  logic        busy_q, busy_d;

  logic        cpu_elig;
  logic        dma_elig;
  logic        col_d;
  logic        ack_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 2'd1;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    dma_d      = dma_q;
    last_dma_d = last_dma_q;
    ra_d       = ra_q;

    cpu_elig = bus.CpuReq && !cpu_served_q;
    // DMA yields once to an eligible CPU after each DMA grant
    dma_elig = bus.DmaReq && !dma_served_q && !(last_dma_q && cpu_elig);

    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (bus.RefUrgent) begin
          state_d = REF_C;
        end else if (dma_elig) begin
          state_d    = ROW;
          addr_d     = bus.DmaA;
          we_d       = 1'b0;
          be_d       = 2'b11;
          dma_d      = 1'b1;
          last_dma_d = 1'b1;
        end else if (cpu_elig) begin
          state_d    = ROW;
          addr_d     = bus.CpuA;
          we_d       = bus.CpuWE;
          be_d       = bus.CpuBE;
          dma_d      = 1'b0;
          last_dma_d = 1'b0;
        end else if (bus.RefReq) begin
          state_d = REF_C;
        end
      end
      ROW: if (cnt_q == 2'(TRCD - 1)) begin
        state_d = COL;
        cnt_d   = 2'd0;
      end
      COL: if (cnt_q == 2'(TCAS - 1)) begin
        state_d = PRE;
        cnt_d   = 2'd0;
      end
      REF_C: begin
        state_d = REF_R;
        cnt_d   = 2'd0;
      end
      REF_R: if (cnt_q == 2'(TRAS_REF - 1)) begin
        state_d = PRE;
        cnt_d   = 2'd0;
      end
      PRE: if (cnt_q == 2'(TRP - 1)) begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    if (state_q == IDLE && state_d == ROW)
      ra_d = {1'b0, addr_d[20:10]};
    else if (state_q == ROW && state_d == COL)
      ra_d = {2'b00, addr_q[9:0]};

    // Outputs are registered, so they are decoded from the next state
    col_d     = (state_d == COL);
    ack_d     = col_d && (cnt_d == 2'(TCAS - 1));
    nras_d    = !(state_d inside {ROW, COL, REF_R});
    ncas_d    = !(state_d inside {COL, REF_C, REF_R});
    noe_d     = !(col_d && !we_d);
    nuwe_d    = !(col_d && we_d && be_d[1]);
    nlwe_d    = !(col_d && we_d && be_d[0]);
    cpu_ack_d = ack_d && !dma_d;
    dma_ack_d = ack_d && dma_d;
    ref_ack_d = (state_d == REF_C);
    busy_d    = (state_d != IDLE);

    cpu_served_d = bus.CpuReq ? (cpu_served_q || cpu_ack_d) : 1'b0;
    dma_served_d = bus.DmaReq ? (dma_served_q || dma_ack_d) : 1'b0;
  end

  always_ff @(posedge CLK_FSB) begin
    if (RES) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= 2'b00;
      dma_q        <= 1'b0;
      last_dma_q   <= 1'b0;
      cpu_served_q <= 1'b0;
      dma_served_q <= 1'b0;
      ra_q         <= '0;
      nras_q       <= 1'b1;
      ncas_q       <= 1'b1;
      nuwe_q       <= 1'b1;
      nlwe_q       <= 1'b1;
      noe_q        <= 1'b1;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      ref_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      dma_q        <= dma_d;
      last_dma_q   <= last_dma_d;
      cpu_served_q <= cpu_served_d;
      dma_served_q <= dma_served_d;
      ra_q         <= ra_d;
      nras_q       <= nras_d;
      ncas_q       <= ncas_d;
      nuwe_q       <= nuwe_d;
      nlwe_q       <= nlwe_d;
      noe_q        <= noe_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      ref_ack_q    <= ref_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.RA      = ra_q;
  assign bus.nRAS    = nras_q;
  assign bus.nCAS    = ncas_q;
  assign bus.nRAMUWE = nuwe_q;
  assign bus.nRAMLWE = nlwe_q;
  assign bus.nOE     = noe_q;
  assign bus.CpuAck  = cpu_ack_q;
  assign bus.DmaAck  = dma_ack_q;
  assign bus.RefAck  = ref_ack_q;
  assign bus.Busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_dram_sched : random requesters against a grant-level timeline model  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_dram_sched;
  localparam int TRCD     = 1;
  localparam int TCAS     = 2;
  localparam int TRP      = 2;
  localparam int TRAS_REF = 3;

  typedef struct packed {
    logic        busy;
    logic        cack;
    logic        dack;
    logic        rack;
    logic        nras;
    logic        ncas;
    logic        nuwe;
    logic        nlwe;
    logic        noe;
    logic [11:0] ra;
  } out_t;

  logic CLK_FSB = 1'b0;
  logic RES     = 1'b1;
  dram_sched_if bus();

  dram_sched #(.TRCD(TRCD), .TCAS(TCAS), .TRP(TRP), .TRAS_REF(TRAS_REF)) u_dut (
    .CLK_FSB (CLK_FSB),
    .RES     (RES),
    .bus     (bus)
  );

  always #5 CLK_FSB = ~CLK_FSB;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (busy,cack,dack,rack,nras,ncas,nuwe,nlwe,noe,ra[11:0])",
               tag, got, exp);
    end
  endtask

  // Model: each grant expands into the full list of expected output cycles
  out_t        plan[$];
  out_t        exp_o;
  logic        m_cpu_srv = 1'b0;
  logic        m_dma_srv = 1'b0;
  logic        m_last_dma = 1'b0;
  logic [11:0] m_ra = '0;

  function automatic out_t quiet(input logic busy, input logic [11:0] ra);
    out_t o;
    o      = '{busy: busy, cack: 1'b0, dack: 1'b0, rack: 1'b0, nras: 1'b1, ncas: 1'b1,
               nuwe: 1'b1, nlwe: 1'b1, noe: 1'b1, ra: ra};
    return o;
  endfunction

  task automatic plan_access(input logic [20:0] a, input logic we, input logic [1:0] be,
                             input logic is_dma);
    out_t        o;
    logic [11:0] row;
    logic [11:0] col;
    row = 12'(a >> 10);
    col = 12'(a % 1024);
    for (int i = 0; i < TRCD; i++) begin
      o = quiet(1'b1, row);
      o.nras = 1'b0;
      plan.push_back(o);
    end
    for (int i = 0; i < TCAS; i++) begin
      o = quiet(1'b1, col);
      o.nras = 1'b0;
      o.ncas = 1'b0;
      if (we) begin
        o.nuwe = ~be[1];
        o.nlwe = ~be[0];
      end else begin
        o.noe = 1'b0;
      end
      if (i == TCAS - 1) begin
        o.cack = !is_dma;
        o.dack = is_dma;
      end
      plan.push_back(o);
    end
    for (int i = 0; i < TRP; i++) plan.push_back(quiet(1'b1, col));
    plan.push_back(quiet(1'b0, col));
  endtask

  task automatic plan_refresh();
    out_t o;
    o = quiet(1'b1, m_ra);
    o.ncas = 1'b0;
    o.rack = 1'b1;
    plan.push_back(o);
    for (int i = 0; i < TRAS_REF; i++) begin
      o = quiet(1'b1, m_ra);
      o.nras = 1'b0;
      o.ncas = 1'b0;
      plan.push_back(o);
    end
    for (int i = 0; i < TRP; i++) plan.push_back(quiet(1'b1, m_ra));
    plan.push_back(quiet(1'b0, m_ra));
  endtask

  task automatic model_step();
    logic cpu_el;
    logic dma_el;
    if (RES) begin
      plan.delete();
      m_cpu_srv  = 1'b0;
      m_dma_srv  = 1'b0;
      m_last_dma = 1'b0;
      m_ra       = '0;
      exp_o      = quiet(1'b0, 12'h000);
      return;
    end
    if (plan.size() == 0) begin
      cpu_el = bus.CpuReq && !m_cpu_srv;
      dma_el = bus.DmaReq && !m_dma_srv && !(m_last_dma && cpu_el);
      if (bus.RefUrgent) begin
        plan_refresh();
      end else if (dma_el) begin
        plan_access(bus.DmaA, 1'b0, 2'b11, 1'b1);
        m_last_dma = 1'b1;
      end else if (cpu_el) begin
        plan_access(bus.CpuA, bus.CpuWE, bus.CpuBE, 1'b0);
        m_last_dma = 1'b0;
      end else if (bus.RefReq) begin
        plan_refresh();
      end
    end
    if (plan.size() != 0) exp_o = plan.pop_front();
    else                  exp_o = quiet(1'b0, m_ra);
    m_ra      = exp_o.ra;
    m_cpu_srv = bus.CpuReq && (m_cpu_srv || exp_o.cack);
    m_dma_srv = bus.DmaReq && (m_dma_srv || exp_o.dack);
  endtask

  task automatic tick(input string tag);
    out_t got;
    model_step();
    @(posedge CLK_FSB);
    #1;
    got = '{busy: bus.Busy, cack: bus.CpuAck, dack: bus.DmaAck, rack: bus.RefAck,
            nras: bus.nRAS, ncas: bus.nCAS, nuwe: bus.nRAMUWE, nlwe: bus.nRAMLWE,
            noe: bus.nOE, ra: bus.RA};
    check(tag, 32'(got), 32'(exp_o));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    bus.CpuReq    = 1'b0;
    bus.CpuWE     = 1'b0;
    bus.CpuBE     = 2'b00;
    bus.CpuA      = '0;
    bus.DmaReq    = 1'b0;
    bus.DmaA      = '0;
    bus.RefReq    = 1'b0;
    bus.RefUrgent = 1'b0;

    run("reset", 3);
    RES = 1'b0;
    run("idle", 2);

    // CPU read of word 0x0ABCDE held past its ack
    bus.CpuReq = 1'b1; bus.CpuA = 21'h0ABCDE; bus.CpuBE = 2'b11; bus.CpuWE = 1'b0;
    run("cpu_rd", 12);
    bus.CpuReq = 1'b0;
    run("cpu_rd_drop", 2);

    // Upper-byte write, held, then dropped for one cycle and re-raised
    bus.CpuReq = 1'b1; bus.CpuA = 21'h12345; bus.CpuBE = 2'b10; bus.CpuWE = 1'b1;
    run("cpu_wr_hold", 16);
    bus.CpuReq = 1'b0;
    run("cpu_wr_gap", 1);
    bus.CpuReq = 1'b1;
    run("cpu_wr_again", 8);
    bus.CpuReq = 1'b0;
    run("cpu_wr_drop", 2);

    // DMA and CPU together, DMA re-raised after each ack
    bus.CpuReq = 1'b1; bus.CpuWE = 1'b0; bus.CpuA = 21'h1F00F;
    bus.DmaReq = 1'b1; bus.DmaA = 21'h0A5A5;
    run("dma_cpu", 4);
    bus.DmaReq = 1'b0;
    run("dma_cpu", 1);
    bus.DmaReq = 1'b1;
    run("dma_cpu", 14);
    bus.CpuReq = 1'b0; bus.DmaReq = 1'b0;
    run("dma_cpu_end", 3);

    // Urgent refresh raised while a CPU access is in COL
    bus.CpuReq = 1'b1; bus.CpuA = 21'h00777;
    run("urg", 2);
    bus.RefUrgent = 1'b1;
    run("urg", 6);
    bus.RefUrgent = 1'b0; bus.CpuReq = 1'b0;
    run("urg_end", 8);

    // Plain refresh alongside CPU, then alone
    bus.CpuReq = 1'b1; bus.RefReq = 1'b1; bus.CpuA = 21'h1ABCD;
    run("ref_cpu", 7);
    bus.CpuReq = 1'b0;
    run("ref_cpu", 7);
    bus.RefReq = 1'b0;
    run("ref_alone_idle", 2);
    bus.RefReq = 1'b1;
    run("ref_alone", 2);
    bus.RefReq = 1'b0;
    run("ref_alone_end", 7);

    // Reset during ROW with a held request
    bus.CpuReq = 1'b1; bus.CpuA = 21'h0F0F0;
    run("res_row", 1);
    RES = 1'b1;
    run("res_row_rst", 1);
    RES = 1'b0;
    run("res_row_after", 10);
    bus.CpuReq = 1'b0;
    run("res_row_end", 2);

    // Random level requests, addresses and occasional reset
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0)   bus.CpuReq    = ~bus.CpuReq;
      if ($urandom_range(0, 7) == 0)   bus.DmaReq    = ~bus.DmaReq;
      if ($urandom_range(0, 15) == 0)  bus.RefReq    = ~bus.RefReq;
      if ($urandom_range(0, 39) == 0)  bus.RefUrgent = ~bus.RefUrgent;
      RES       = ($urandom_range(0, 199) == 0);
      bus.CpuA  = 21'($urandom);
      bus.DmaA  = 21'($urandom);
      bus.CpuWE = 1'($urandom);
      bus.CpuBE = 2'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
